// File: rtl/td4_pkg.sv
// Shared encodings for the TD4 execution controller: command opcodes and FSM states.
package td4_pkg;

   typedef enum logic [1:0] {
      OP_RUN   = 2'b00,
      OP_HALT  = 2'b01,
      OP_STEP  = 2'b10,
      OP_WRITE = 2'b11
   } cmd_op_t;

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_LOAD = 2'b11
   } state_t;

   localparam int CNT_W = 8;

endpackage

// File: rtl/td4_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module td4_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   // Count enabled cycles, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (clear) begin
         r_q <= '0;
      end else if (inc && (r_q != {W{1'b1}})) begin
         r_q <= r_q + 1'b1;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/td4_exec_ctrl.sv
// Debug/execution controller for a TD4 core: run/halt/single-step with one
// PC breakpoint, optional run-length limit, and an instruction-memory write port.
module td4_exec_ctrl
   import td4_pkg::*;
#(
   parameter logic [7:0] RUN_LIMIT = 8'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_addr,
   input  logic [7:0] cmd_data,
   input  logic       bp_en,
   input  logic [3:0] bp_addr,
   input  logic [3:0] cpu_addr,
   output logic       cpu_en,
   output logic       mem_we,
   output logic [3:0] mem_waddr,
   output logic [7:0] mem_wdata,
   output logic       halted,
   output logic       bp_hit,
   output logic [7:0] step_cnt
);

   state_t       r_state;
   state_t       w_state_next;
   logic         r_bp_skip;
   logic         r_bp_hit;
   logic [3:0]   r_waddr;
   logic [7:0]   r_wdata;

   logic         w_accept;
   logic         w_bp_stop;
   logic         w_limit_stop;
   logic         w_cnt_clear;
   logic         w_bp_hit_set;
   logic         w_bp_hit_clr;
   logic         w_skip_set;
   logic         w_latch_wr;
   logic [7:0]   w_step_cnt;
   cmd_op_t      w_op;

   assign w_op      = cmd_op_t'(cmd_op);
   assign cmd_ready = (r_state == ST_HALT) || (r_state == ST_RUN);
   assign w_accept  = cmd_valid && cmd_ready;

   // The skip flag lets a RUN resumed at a breakpoint execute that instruction.
   assign w_bp_stop    = bp_en && (cpu_addr == bp_addr) && !r_bp_skip;
   assign w_limit_stop = (RUN_LIMIT != 8'd0) && (w_step_cnt == RUN_LIMIT);

   assign cpu_en    = ((r_state == ST_RUN) && !w_bp_stop && !w_limit_stop) ||
                      (r_state == ST_STEP);
   assign mem_we    = (r_state == ST_LOAD);
   assign mem_waddr = r_waddr;
   assign mem_wdata = r_wdata;
   assign halted    = (r_state == ST_HALT);
   assign bp_hit    = r_bp_hit;
   assign step_cnt  = w_step_cnt;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_HALT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and side-effect strobes; stops in RUN take priority over HALT.
   always_comb begin
      w_state_next = r_state;
      w_cnt_clear  = 1'b0;
      w_bp_hit_set = 1'b0;
      w_bp_hit_clr = 1'b0;
      w_skip_set   = 1'b0;
      w_latch_wr   = 1'b0;
      case (r_state)
         ST_HALT: begin
            if (w_accept) begin
               case (w_op)
                  OP_RUN: begin
                     w_state_next = ST_RUN;
                     w_cnt_clear  = 1'b1;
                     w_skip_set   = 1'b1;
                     w_bp_hit_clr = 1'b1;
                  end
                  OP_STEP: begin
                     w_state_next = ST_STEP;
                     w_cnt_clear  = 1'b1;
                     w_bp_hit_clr = 1'b1;
                  end
                  OP_WRITE: begin
                     w_state_next = ST_LOAD;
                     w_latch_wr   = 1'b1;
                     w_bp_hit_clr = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            if (w_bp_stop) begin
               w_state_next = ST_HALT;
               w_bp_hit_set = 1'b1;
            end else if (w_limit_stop) begin
               w_state_next = ST_HALT;
            end else if (w_accept && (w_op == OP_HALT)) begin
               w_state_next = ST_HALT;
            end
         end
         ST_STEP: w_state_next = ST_HALT;
         ST_LOAD: w_state_next = ST_HALT;
         default: w_state_next = ST_HALT;
      endcase
   end

   // Sticky breakpoint flag, one-shot breakpoint skip, and latched write target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bp_hit  <= 1'b0;
         r_bp_skip <= 1'b0;
         r_waddr   <= 4'd0;
         r_wdata   <= 8'd0;
      end else begin
         if (w_bp_hit_set) begin
            r_bp_hit <= 1'b1;
         end else if (w_bp_hit_clr) begin
            r_bp_hit <= 1'b0;
         end
         if (w_skip_set) begin
            r_bp_skip <= 1'b1;
         end else if (r_state == ST_RUN) begin
            r_bp_skip <= 1'b0;
         end
         if (w_latch_wr) begin
            r_waddr <= cmd_addr;
            r_wdata <= cmd_data;
         end
      end
   end

   td4_sat_cnt #(
      .W (CNT_W)
   ) u_step_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (w_cnt_clear),
      .inc   (cpu_en),
      .q     (w_step_cnt)
   );

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// Directed bench for td4_exec_ctrl: one unlimited instance and one with RUN_LIMIT=5
// driven by the same stimulus; expectations go through a FIFO scoreboard.
module tb_td4_exec_ctrl;
   import td4_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_addr = 4'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       bp_en = 1'b0;
   logic [3:0] bp_addr = 4'd0;
   logic [3:0] cpu_addr = 4'd0;

   logic       cmd_ready, cpu_en, mem_we, halted, bp_hit;
   logic [3:0] mem_waddr;
   logic [7:0] mem_wdata, step_cnt;

   logic       l_cmd_ready, l_cpu_en, l_mem_we, l_halted, l_bp_hit;
   logic [3:0] l_mem_waddr;
   logic [7:0] l_mem_wdata, l_step_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   td4_exec_ctrl #(.RUN_LIMIT(8'd0)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .bp_en(bp_en), .bp_addr(bp_addr), .cpu_addr(cpu_addr), .cpu_en(cpu_en),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .halted(halted), .bp_hit(bp_hit), .step_cnt(step_cnt)
   );

   td4_exec_ctrl #(.RUN_LIMIT(8'd5)) dut_lim (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(l_cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .bp_en(bp_en), .bp_addr(bp_addr), .cpu_addr(cpu_addr), .cpu_en(l_cpu_en),
      .mem_we(l_mem_we), .mem_waddr(l_mem_waddr), .mem_wdata(l_mem_wdata),
      .halted(l_halted), .bp_hit(l_bp_hit), .step_cnt(l_step_cnt)
   );

   task automatic push(input string tag, input logic [7:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic cmp(input logic [7:0] obs);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty observed=%0h expected=none", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   // One clock; the bench plays the core, advancing the PC on each enabled cycle.
   task automatic tick();
      logic adv;
      #1;
      adv = cpu_en;
      @(posedge clk);
      #1;
      if (adv) cpu_addr = cpu_addr + 4'd1;
      #1;
   endtask

   task automatic drive_cmd(input cmd_op_t op, input logic [3:0] a, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
      #1;
   endtask

   task automatic idle();
      cmd_valid = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cpu_addr  = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state, checked before any clock edge.
      #1;
      push("rst_halted", 8'd1);    cmp(halted);
      push("rst_cpu_en", 8'd0);    cmp(cpu_en);
      push("rst_mem_we", 8'd0);    cmp(mem_we);
      push("rst_waddr", 8'd0);     cmp(mem_waddr);
      push("rst_wdata", 8'd0);     cmp(mem_wdata);
      push("rst_bp_hit", 8'd0);    cmp(bp_hit);
      push("rst_step_cnt", 8'd0);  cmp(step_cnt);
      push("rst_cmd_ready", 8'd1); cmp(cmd_ready);
      do_reset();

      // WRITE from HALT: one write cycle with the latched address/data.
      drive_cmd(OP_WRITE, 4'd3, 8'hB5);
      push("wr_ready", 8'd1);   push("wr_we", 8'd1);     push("wr_addr", 8'd3);
      push("wr_data", 8'hB5);   push("wr_busy", 8'd0);   push("wr_halted_in_load", 8'd0);
      push("wr_we_after", 8'd0); push("wr_halted_after", 8'd1);
      cmp(cmd_ready);
      tick(); idle();
      cmp(mem_we); cmp(mem_waddr); cmp(mem_wdata); cmp(cmd_ready); cmp(halted);
      tick();
      cmp(mem_we); cmp(halted);

      // STEP from HALT: exactly one enabled cycle.
      drive_cmd(OP_STEP, 4'd0, 8'd0);
      push("step_en", 8'd1); push("step_en_after", 8'd0);
      push("step_halted", 8'd1); push("step_cnt", 8'd1);
      tick(); idle();
      cmp(cpu_en);
      tick();
      cmp(cpu_en); cmp(halted); cmp(step_cnt);

      // Breakpoint at PC 4, then resume through it and HALT.
      do_reset();
      bp_en = 1'b1; bp_addr = 4'd4;
      drive_cmd(OP_RUN, 4'd0, 8'd0);
      tick(); idle();
      for (int i = 0; i < 4; i++) begin
         push("bp_run_en", 8'd1);
         cmp(cpu_en);
         tick();
      end
      push("bp_stop_pc", 8'd4); push("bp_stop_en", 8'd0);
      cmp(cpu_addr); cmp(cpu_en);
      tick();
      push("bp_halted", 8'd1); push("bp_hit", 8'd1); push("bp_step_cnt", 8'd4);
      cmp(halted); cmp(bp_hit); cmp(step_cnt);
      drive_cmd(OP_RUN, 4'd0, 8'd0);
      tick(); idle();
      push("resume_en_at_bp", 8'd1); push("resume_bp_hit", 8'd0);
      cmp(cpu_en); cmp(bp_hit);
      tick();
      drive_cmd(OP_HALT, 4'd0, 8'd0);
      push("halt_accept_en", 8'd1);
      cmp(cpu_en);
      tick(); idle();
      push("halt_halted", 8'd1); push("halt_step_cnt", 8'd2);
      cmp(halted); cmp(step_cnt);

      // HALT command coinciding with a breakpoint match.
      do_reset();
      bp_en = 1'b1; bp_addr = 4'd3;
      drive_cmd(OP_RUN, 4'd0, 8'd0);
      tick(); idle();
      for (int i = 0; i < 3; i++) begin
         push("coin_run_en", 8'd1);
         cmp(cpu_en);
         tick();
      end
      drive_cmd(OP_HALT, 4'd0, 8'd0);
      push("coin_en", 8'd0); push("coin_running", 8'd0);
      cmp(cpu_en); cmp(halted);
      tick(); idle();
      push("coin_halted", 8'd1); push("coin_bp_hit", 8'd1);
      cmp(halted); cmp(bp_hit);

      // Run limit of 5 on the limited instance; the unlimited one keeps going.
      do_reset();
      bp_en = 1'b0;
      drive_cmd(OP_RUN, 4'd0, 8'd0);
      tick(); idle();
      for (int i = 0; i < 5; i++) begin
         push("lim_run_en", 8'd1);
         cmp(l_cpu_en);
         tick();
      end
      push("lim_stop_en", 8'd0);
      cmp(l_cpu_en);
      tick();
      push("lim_halted", 8'd1); push("lim_step_cnt", 8'd5); push("lim_bp_hit", 8'd0);
      push("unlim_still_running", 8'd1);
      cmp(l_halted); cmp(l_step_cnt); cmp(l_bp_hit); cmp(cpu_en);

      // Long run saturates the cycle counter.
      repeat (260) tick();
      push("sat_step_cnt", 8'd255); push("sat_en", 8'd1);
      cmp(step_cnt); cmp(cpu_en);

      // WRITE during RUN is consumed without a write; the halted instance does write.
      drive_cmd(OP_WRITE, 4'd9, 8'h5A);
      push("runwr_ready", 8'd1);
      cmp(cmd_ready);
      tick(); idle();
      push("runwr_we", 8'd0); push("runwr_running", 8'd0); push("runwr_en", 8'd1);
      push("lim_wr_we", 8'd1); push("lim_wr_addr", 8'd9); push("lim_wr_data", 8'h5A);
      cmp(mem_we); cmp(halted); cmp(cpu_en);
      cmp(l_mem_we); cmp(l_mem_waddr); cmp(l_mem_wdata);
      tick();
      push("runwr_we2", 8'd0);
      cmp(mem_we);

      // Asynchronous reset mid-RUN: takes effect before the next clock edge.
      rst_n = 1'b0;
      #1;
      push("arst_en", 8'd0); push("arst_halted", 8'd1);
      push("arst_step_cnt", 8'd0); push("arst_we", 8'd0);
      cmp(cpu_en); cmp(halted); cmp(step_cnt); cmp(mem_we);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
